// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit memory controller.
// Holds funct3 codes, FSM states and lane/enable helper functions.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE
  } lsu_state_t;

  function automatic logic [3:0] be_gen(
    input logic [2:0] funct3,
    input logic [1:0] off
  );
    logic [3:0] be;
    be = 4'b1111;
    unique case (funct3[1:0])
      2'b00:   be = 4'b0001 << off;
      2'b01:   be = 4'b0011 << off;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] wdata_rep(
    input logic [2:0]  funct3,
    input logic [31:0] wd
  );
    logic [31:0] r;
    r = wd;
    unique case (funct3[1:0])
      2'b00:   r = {4{wd[7:0]}};
      2'b01:   r = {2{wd[15:0]}};
      default: r = wd;
    endcase
    return r;
  endfunction

  // Stores only exist as SB/SH/SW; unsigned forms are load-only.
  function automatic logic access_ok(
    input logic       we,
    input logic [2:0] funct3,
    input logic [1:0] off
  );
    logic ok;
    ok = 1'b0;
    unique case (funct3)
      F3_B:    ok = 1'b1;
      F3_H:    ok = ~off[0];
      F3_W:    ok = (off == 2'b00);
      F3_BU:   ok = ~we;
      F3_HU:   ok = ~we & ~off[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/lsu_mem_ctrl_load_align.sv
// Selects the addressed byte/half of a memory word and extends it.
// Purely combinational so other refill paths can share it.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  off_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b = word_i[7:0];
    unique case (off_i)
      2'd0: b = word_i[7:0];
      2'd1: b = word_i[15:8];
      2'd2: b = word_i[23:16];
      2'd3: b = word_i[31:24];
    endcase
    h = off_i[1] ? word_i[31:16] : word_i[15:0];
  end

  always_comb begin
    data_o = word_i;
    unique case (funct3_i)
      F3_B:    data_o = {{24{b[7]}}, b};
      F3_BU:   data_o = {24'h0, b};
      F3_H:    data_o = {{16{h[15]}}, h};
      F3_HU:   data_o = {16'h0, h};
      default: data_o = word_i;
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// MEM-stage load/store initiator toward a handshaked data memory.
// Stalls the pipe per access, extends loads, flags faults/timeouts.
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             lsu_req,
  input  logic             lsu_we,
  input  logic [2:0]       lsu_funct3,
  input  logic [WIDTH-1:0] lsu_addr,
  input  logic [WIDTH-1:0] lsu_wdata,
  output logic             lsu_stall,
  output logic             lsu_done,
  output logic [WIDTH-1:0] lsu_rdata,
  output logic             lsu_fault,
  output logic             mem_req_valid,
  input  logic             mem_req_ready,
  output logic             mem_req_we,
  output logic [WIDTH-1:0] mem_req_addr,
  output logic [3:0]       mem_req_be,
  output logic [WIDTH-1:0] mem_req_wdata,
  input  logic             mem_resp_valid,
  input  logic [WIDTH-1:0] mem_resp_rdata
);

  localparam int CW = $clog2(TIMEOUT + 1);

  lsu_state_t       state_q, state_d;
  logic             we_q, we_d;
  logic [2:0]       f3_q, f3_d;
  logic [1:0]       off_q, off_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic [3:0]       be_q, be_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             fault_q, fault_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [WIDTH-1:0] ld_ext;
  logic             tmo;

  lsu_load_align u_align (
    .word_i   (mem_resp_rdata),
    .off_i    (off_q),
    .funct3_i (f3_q),
    .data_o   (ld_ext)
  );

  assign tmo = (cnt_q == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      f3_q    <= 3'b0;
      off_q   <= 2'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= 4'b0;
      rdata_q <= '0;
      fault_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      off_q   <= off_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
      fault_q <= fault_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    we_d          = we_q;
    f3_d          = f3_q;
    off_d         = off_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    be_d          = be_q;
    rdata_d       = rdata_q;
    fault_d       = fault_q;
    cnt_d         = cnt_q;
    mem_req_valid = 1'b0;
    lsu_done      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (lsu_req) begin
          we_d    = lsu_we;
          f3_d    = lsu_funct3;
          off_d   = lsu_addr[1:0];
          addr_d  = {lsu_addr[WIDTH-1:2], 2'b00};
          be_d    = be_gen(lsu_funct3, lsu_addr[1:0]);
          wdata_d = wdata_rep(lsu_funct3, lsu_wdata);
          if (access_ok(lsu_we, lsu_funct3, lsu_addr[1:0])) begin
            state_d = S_REQ;
            cnt_d   = '0;
          end else begin
            state_d = S_DONE;
            fault_d = 1'b1;
            rdata_d = '0;
          end
        end
      end
      S_REQ: begin
        cnt_d = cnt_q + CW'(1);
        if (tmo) begin
          state_d = S_DONE;
          fault_d = 1'b1;
          rdata_d = '0;
        end else begin
          mem_req_valid = 1'b1;
          if (mem_req_ready) begin
            if (we_q) begin
              state_d = S_DONE;
              fault_d = 1'b0;
              rdata_d = '0;
            end else begin
              state_d = S_WAIT;
            end
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + CW'(1);
        if (mem_resp_valid) begin
          state_d = S_DONE;
          fault_d = 1'b0;
          rdata_d = ld_ext;
        end else if (tmo) begin
          state_d = S_DONE;
          fault_d = 1'b1;
          rdata_d = '0;
        end
      end
      S_DONE: begin
        lsu_done = 1'b1;
        state_d  = S_IDLE;
      end
    endcase
  end

  // Stall is combinational so the first request cycle already holds the pipe.
  assign lsu_stall = (state_q == S_REQ) | (state_q == S_WAIT)
                   | ((state_q == S_IDLE) & lsu_req);

  assign lsu_rdata     = rdata_q;
  assign lsu_fault     = fault_q;
  assign mem_req_we    = we_q;
  assign mem_req_addr  = addr_q;
  assign mem_req_be    = be_q;
  assign mem_req_wdata = wdata_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Scoreboard bench for lsu_mem_ctrl: directed accesses, faults,
// timeout and reset-during-access, checked by decoupled monitors.
module tb_lsu_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        lsu_req = 1'b0;
  logic        lsu_we = 1'b0;
  logic [2:0]  lsu_funct3 = 3'b0;
  logic [31:0] lsu_addr = 32'h0;
  logic [31:0] lsu_wdata = 32'h0;
  logic        lsu_stall;
  logic        lsu_done;
  logic [31:0] lsu_rdata;
  logic        lsu_fault;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b1;
  logic        mem_req_we;
  logic [31:0] mem_req_addr;
  logic [3:0]  mem_req_be;
  logic [31:0] mem_req_wdata;
  logic        mem_resp_valid = 1'b0;
  logic [31:0] mem_resp_rdata = 32'h0;

  lsu_mem_ctrl #(.WIDTH(32), .TIMEOUT(8)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .lsu_req        (lsu_req),
    .lsu_we         (lsu_we),
    .lsu_funct3     (lsu_funct3),
    .lsu_addr       (lsu_addr),
    .lsu_wdata      (lsu_wdata),
    .lsu_stall      (lsu_stall),
    .lsu_done       (lsu_done),
    .lsu_rdata      (lsu_rdata),
    .lsu_fault      (lsu_fault),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_we     (mem_req_we),
    .mem_req_addr   (mem_req_addr),
    .mem_req_be     (mem_req_be),
    .mem_req_wdata  (mem_req_wdata),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_rdata (mem_resp_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic [31:0] rd;
    logic        f;
  } resp_t;

  typedef struct {
    string       nm;
    logic        we;
    logic [31:0] a;
    logic [3:0]  be;
    logic [31:0] wd;
  } req_t;

  resp_t rsp_q[$];
  req_t  req_q[$];

  int tests = 0;
  int fails = 0;

  int          hold = 0;
  bit          resp_en = 1'b1;
  bit          late_pulse = 1'b0;
  bit          pend = 1'b0;
  logic [31:0] mem_word = 32'h0;

  // Memory model: ready back-pressure, request checking, response one cycle later.
  always @(negedge clk) begin
    req_t r;
    mem_resp_valid = pend | late_pulse;
    mem_resp_rdata = late_pulse ? 32'h0BAD0BAD : mem_word;
    pend = 1'b0;
    if (mem_req_valid && hold > 0) begin
      mem_req_ready = 1'b0;
      hold--;
      tests++;
      if (req_q.size() == 0) begin
        fails++;
        $display("FAIL hold_unexpected_req addr=%h", mem_req_addr);
      end else if ({mem_req_we, mem_req_addr, mem_req_be, mem_req_wdata} !==
                   {req_q[0].we, req_q[0].a, req_q[0].be, req_q[0].wd}) begin
        fails++;
        $display("FAIL hold_stable_%s got we=%b a=%h be=%b wd=%h exp we=%b a=%h be=%b wd=%h",
                 req_q[0].nm, mem_req_we, mem_req_addr, mem_req_be, mem_req_wdata,
                 req_q[0].we, req_q[0].a, req_q[0].be, req_q[0].wd);
      end
    end else begin
      mem_req_ready = 1'b1;
    end
    if (mem_req_valid && mem_req_ready) begin
      tests++;
      if (req_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_req got addr=%h be=%b", mem_req_addr, mem_req_be);
      end else begin
        r = req_q.pop_front();
        if ({mem_req_we, mem_req_addr, mem_req_be, mem_req_wdata} !==
            {r.we, r.a, r.be, r.wd}) begin
          fails++;
          $display("FAIL req_%s got we=%b a=%h be=%b wd=%h exp we=%b a=%h be=%b wd=%h",
                   r.nm, mem_req_we, mem_req_addr, mem_req_be, mem_req_wdata,
                   r.we, r.a, r.be, r.wd);
        end
      end
      if (!mem_req_we && resp_en) pend = 1'b1;
    end
  end

  // Completion monitor.
  always @(negedge clk) begin
    resp_t e;
    if (rst_n && lsu_done) begin
      tests++;
      if (rsp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_done got rdata=%h fault=%b", lsu_rdata, lsu_fault);
      end else begin
        e = rsp_q.pop_front();
        if (lsu_rdata !== e.rd || lsu_fault !== e.f) begin
          fails++;
          $display("FAIL done_%s got rdata=%h fault=%b exp rdata=%h fault=%b",
                   e.nm, lsu_rdata, lsu_fault, e.rd, e.f);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic issue(
    input string       nm,
    input bit          we,
    input logic [2:0]  f3,
    input logic [31:0] a,
    input logic [31:0] wd,
    input logic [31:0] word,
    input bit          has_req,
    input logic [31:0] ea,
    input logic [3:0]  ebe,
    input logic [31:0] ewd,
    input logic [31:0] erd,
    input bit          ef,
    input int          est,
    input int          h
  );
    int  n;
    bit  got;
    resp_t e;
    req_t  r;
    @(negedge clk);
    e.nm = nm; e.rd = erd; e.f = ef;
    rsp_q.push_back(e);
    if (has_req) begin
      r.nm = nm; r.we = we; r.a = ea; r.be = ebe; r.wd = ewd;
      req_q.push_back(r);
    end
    hold = h;
    mem_word = word;
    lsu_req = 1'b1;
    lsu_we = we;
    lsu_funct3 = f3;
    lsu_addr = a;
    lsu_wdata = wd;
    #1;
    n = lsu_stall ? 1 : 0;
    got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (lsu_done) begin
        got = 1'b1;
        break;
      end
      if (lsu_stall) n++;
    end
    lsu_req = 1'b0;
    tests++;
    if (!got) begin
      fails++;
      $display("FAIL wait_done_%s got no lsu_done exp done within 100 cycles", nm);
    end
    chk({"stall_cycles_", nm}, 64'(n), 64'(est));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got no finish exp finish");
    $fatal(1);
  end

  initial begin
    req_t r;
    repeat (2) @(negedge clk);
    chk("reset_outputs",
        {27'h0, mem_req_valid, lsu_stall, lsu_done, lsu_fault, mem_req_we, mem_req_be},
        64'h0);
    chk("reset_data", {lsu_rdata, mem_req_addr | mem_req_wdata}, 64'h0);
    rst_n = 1'b1;

    issue("lw", 0, 3'b010, 32'h0000_1004, 32'h0, 32'hDEAD_BEEF,
          1, 32'h0000_1004, 4'b1111, 32'h0, 32'hDEAD_BEEF, 0, 3, 0);
    issue("lb", 0, 3'b000, 32'h0000_1003, 32'h0, 32'h80FF_1234,
          1, 32'h0000_1000, 4'b1000, 32'h0, 32'hFFFF_FF80, 0, 3, 0);
    issue("lbu", 0, 3'b100, 32'h0000_1003, 32'h0, 32'h80FF_1234,
          1, 32'h0000_1000, 4'b1000, 32'h0, 32'h0000_0080, 0, 3, 0);
    issue("lhu", 0, 3'b101, 32'h0000_1002, 32'h0, 32'h80FF_1234,
          1, 32'h0000_1000, 4'b1100, 32'h0, 32'h0000_80FF, 0, 3, 0);
    issue("lh", 0, 3'b001, 32'h0000_1002, 32'h0, 32'h80FF_1234,
          1, 32'h0000_1000, 4'b1100, 32'h0, 32'hFFFF_80FF, 0, 3, 0);
    issue("lb_pos", 0, 3'b000, 32'h0000_1001, 32'h0, 32'h80FF_1234,
          1, 32'h0000_1000, 4'b0010, 32'h0, 32'h0000_0012, 0, 3, 0);
    issue("sh_wait", 1, 3'b001, 32'h0000_1002, 32'h1234_ABCD, 32'h0,
          1, 32'h0000_1000, 4'b1100, 32'hABCD_ABCD, 32'h0, 0, 5, 3);
    issue("sb", 1, 3'b000, 32'h0000_1001, 32'h0000_00A5, 32'h0,
          1, 32'h0000_1000, 4'b0010, 32'hA5A5_A5A5, 32'h0, 0, 2, 0);
    issue("sw", 1, 3'b010, 32'h0000_1008, 32'hCAFE_F00D, 32'h0,
          1, 32'h0000_1008, 4'b1111, 32'hCAFE_F00D, 32'h0, 0, 2, 0);
    issue("lw_mis", 0, 3'b010, 32'h0000_1001, 32'h0, 32'h0,
          0, 32'h0, 4'b0, 32'h0, 32'h0, 1, 1, 0);
    issue("lh_mis", 0, 3'b001, 32'h0000_1003, 32'h0, 32'h0,
          0, 32'h0, 4'b0, 32'h0, 32'h0, 1, 1, 0);
    issue("f3_011", 0, 3'b011, 32'h0000_1000, 32'h0, 32'h0,
          0, 32'h0, 4'b0, 32'h0, 32'h0, 1, 1, 0);
    issue("sbu_ill", 1, 3'b100, 32'h0000_1000, 32'h55, 32'h0,
          0, 32'h0, 4'b0, 32'h0, 32'h0, 1, 1, 0);
    issue("lw_ok", 0, 3'b010, 32'h0000_100C, 32'h0, 32'h0246_8ACE,
          1, 32'h0000_100C, 4'b1111, 32'h0, 32'h0246_8ACE, 0, 3, 0);

    resp_en = 1'b0;
    issue("lw_tmo", 0, 3'b010, 32'h0000_1010, 32'h0, 32'h1111_1111,
          1, 32'h0000_1010, 4'b1111, 32'h0, 32'h0, 1, 9, 0);
    @(negedge clk);
    chk("tmo_after", {61'h0, mem_req_valid, lsu_stall, lsu_done}, 64'h0);
    #2 late_pulse = 1'b1;
    @(negedge clk);
    #2 late_pulse = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("tmo_late_resp", {62'h0, lsu_done, mem_req_valid}, 64'h0);
    end

    @(negedge clk);
    r.nm = "lw_rst"; r.we = 1'b0; r.a = 32'h0000_3000; r.be = 4'b1111; r.wd = 32'h0;
    req_q.push_back(r);
    lsu_req = 1'b1;
    lsu_we = 1'b0;
    lsu_funct3 = 3'b010;
    lsu_addr = 32'h0000_3000;
    lsu_wdata = 32'h0;
    repeat (2) @(negedge clk);
    chk("rst_pre_stall", {63'h0, lsu_stall}, 64'h1);
    rst_n = 1'b0;
    lsu_req = 1'b0;
    #1;
    chk("rst_mid_outputs",
        {27'h0, mem_req_valid, lsu_stall, lsu_done, lsu_fault, mem_req_we, mem_req_be},
        64'h0);
    chk("rst_mid_data", {lsu_rdata, mem_req_addr | mem_req_wdata}, 64'h0);
    @(negedge clk);
    #2 late_pulse = 1'b1;
    @(negedge clk);
    #2 late_pulse = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #2 late_pulse = 1'b1;
    @(negedge clk);
    #2 late_pulse = 1'b0;
    @(negedge clk);
    chk("rst_idle", {62'h0, lsu_done, mem_req_valid}, 64'h0);
    resp_en = 1'b1;
    issue("lw_after_rst", 0, 3'b010, 32'h0000_2000, 32'h0, 32'h1357_9BDF,
          1, 32'h0000_2000, 4'b1111, 32'h0, 32'h1357_9BDF, 0, 3, 0);

    repeat (3) @(negedge clk);
    chk("queues_empty", 64'(rsp_q.size() + req_q.size()), 64'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
